// File: rtl/wilson_array.sv
// wilson_array: time-multiplexed Wilson neuron solver, one midpoint or Euler step over all cells per start
module wilson_array #(
  parameter int WIDTH = 32,
  parameter int FRAC = 16,
  parameter int NEURONS = 4,
  parameter int ADDR_W = 2,
  parameter logic [WIDTH-1:0] DT = 32'h0000_0042,
  parameter logic [WIDTH-1:0] V_INIT = 32'h8000_CCCD,
  parameter logic [WIDTH-1:0] R_INIT = 32'h0000_0000,
  parameter logic [WIDTH-1:0] VTH = 32'h0000_0000,
  parameter logic [WIDTH-1:0] C_INV = 32'h0001_4000,
  parameter logic [WIDTH-1:0] A = 32'h8028_C99A,
  parameter logic [WIDTH-1:0] B = 32'h8025_3454,
  parameter logic [WIDTH-1:0] C = 32'h8020_8000,
  parameter logic [WIDTH-1:0] D = 32'h000A_89C1,
  parameter logic [WIDTH-1:0] E = 32'h801D_E666,
  parameter logic [WIDTH-1:0] F = 32'h000C_3E91,
  parameter logic [WIDTH-1:0] G = 32'h0000_B5E5,
  parameter logic [WIDTH-1:0] H = 32'h8000_86BC,
  parameter logic [WIDTH-1:0] J = 32'h0000_8A7C
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [NEURONS*WIDTH-1:0]   cur_in,
  output logic                       busy,
  output logic                       done,
  output logic [NEURONS-1:0]         spike,
  output logic                       ovf,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [WIDTH-1:0]           rd_v,
  output logic [WIDTH-1:0]           rd_r
);
  localparam int W = WIDTH;
  typedef enum logic [2:0] {IDLE, EVAL_H, EVAL_F, WRITE, DONE} state_t;
  function automatic logic [W:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = ({{(W+1){1'b0}}, a[W-2:0]} * {{(W+1){1'b0}}, b[W-2:0]}) >> FRAC;
    return {|p[2*W-1:W-1], a[W-1] ^ b[W-1], |p[2*W-1:W-1] ? {(W-1){1'b1}} : p[W-2:0]};
  endfunction
  function automatic logic [W:0] add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    logic sn;
    s = a[W-1] == b[W-1] ? {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} :
        a[W-2:0] >= b[W-2:0] ? {1'b0, a[W-2:0] - b[W-2:0]} : {1'b0, b[W-2:0] - a[W-2:0]};
    sn = a[W-1] == b[W-1] || a[W-2:0] >= b[W-2:0] ? a[W-1] : b[W-1];
    return {s[W-1], sn & |s, s[W-1] ? {(W-1){1'b1}} : s[W-2:0]};
  endfunction
  function automatic logic signed [W-1:0] sval(input logic [W-1:0] a);
    return a[W-1] ? -$signed({1'b0, a[W-2:0]}) : $signed({1'b0, a[W-2:0]});
  endfunction
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic mode_q;
  logic [NEURONS*WIDTH-1:0] cur_q;
  logic [W-1:0] v_mem [NEURONS];
  logic [W-1:0] r_mem [NEURONS];
  logic [W-1:0] v_m, r_m, v_n, r_n;
  logic [W-1:0] cur_v, cur_r, ev, er, ic, hdt;
  logic [W-1:0] x [23];
  logic [22:0] f;
  logic sat, rd_ok;
  assign cur_v = v_mem[idx];
  assign cur_r = r_mem[idx];
  assign ic = cur_q[idx*WIDTH +: WIDTH];
  assign ev = state == EVAL_F && !mode_q ? v_m : cur_v;
  assign er = state == EVAL_F && !mode_q ? r_m : cur_r;
  assign hdt = state == EVAL_H ? DT >> 1 : DT;
  assign sat = |f;
  if (NEURONS == 2**ADDR_W) begin : g_full
    assign rd_ok = 1'b1;
  end else begin : g_part
    assign rd_ok = 32'(rd_addr) < NEURONS;
  end
  always_comb begin
    {f[0], x[0]} = mul(ev, ev);
    {f[1], x[1]} = mul(ev, x[0]);
    {f[2], x[2]} = mul(C_INV, ic);
    {f[3], x[3]} = mul(A, x[1]);
    {f[4], x[4]} = mul(B, x[0]);
    {f[5], x[5]} = mul(C, er);
    {f[6], x[6]} = mul(x[5], ev);
    {f[7], x[7]} = mul(D, ev);
    {f[8], x[8]} = mul(E, er);
    {f[9], x[9]} = add(x[2], x[3]);
    {f[10], x[10]} = add(x[9], x[4]);
    {f[11], x[11]} = add(x[10], x[6]);
    {f[12], x[12]} = add(x[11], x[7]);
    {f[13], x[13]} = add(x[12], x[8]);
    {f[14], x[14]} = add(x[13], F);
    {f[15], x[15]} = mul(G, ev);
    {f[16], x[16]} = mul(H, er);
    {f[17], x[17]} = add(x[15], x[16]);
    {f[18], x[18]} = add(x[17], J);
    {f[19], x[19]} = mul(x[14], hdt);
    {f[20], x[20]} = mul(x[18], hdt);
    {f[21], x[21]} = add(cur_v, x[19]);
    {f[22], x[22]} = add(cur_r, x[20]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      mode_q <= 1'b0;
      cur_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      spike <= '0;
      ovf <= 1'b0;
      v_m <= '0;
      r_m <= '0;
      v_n <= '0;
      r_n <= '0;
      rd_v <= V_INIT;
      rd_r <= R_INIT;
      for (int k = 0; k < NEURONS; k++) begin
        v_mem[k] <= V_INIT;
        r_mem[k] <= R_INIT;
      end
    end else begin
      done <= 1'b0;
      rd_v <= rd_ok ? v_mem[rd_addr] : '0;
      rd_r <= rd_ok ? r_mem[rd_addr] : '0;
      ovf <= ovf | ((state == EVAL_H || state == EVAL_F) && sat);
      case (state)
        IDLE: if (start && !done) begin
          mode_q <= mode;
          cur_q <= cur_in;
          idx <= '0;
          busy <= 1'b1;
          spike <= '0;
          state <= mode ? EVAL_F : EVAL_H;
        end
        EVAL_H: begin
          v_m <= x[21];
          r_m <= x[22];
          state <= EVAL_F;
        end
        EVAL_F: begin
          v_n <= x[21];
          r_n <= x[22];
          state <= WRITE;
        end
        WRITE: begin
          v_mem[idx] <= v_n;
          r_mem[idx] <= r_n;
          spike[idx] <= sval(cur_v) < sval(VTH) && sval(v_n) >= sval(VTH);
          idx <= idx + 1'b1;
          state <= idx == ADDR_W'(NEURONS - 1) ? DONE : mode_q ? EVAL_F : EVAL_H;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wilson_array.sv
// tb_wilson_array: directed steps against a signed-integer reference model with a readback scoreboard
module tb_wilson_array;
  localparam int N = 4;
  localparam logic [31:0] DT = 32'h0000_0042, V_INIT = 32'h8000_CCCD, R_INIT = 32'h0;
  localparam logic [31:0] VTH = 32'h0, CI = 32'h0001_4000;
  localparam logic [31:0] A = 32'h8028_C99A, B = 32'h8025_3454, C = 32'h8020_8000;
  localparam logic [31:0] D = 32'h000A_89C1, E = 32'h801D_E666, F = 32'h000C_3E91;
  localparam logic [31:0] G = 32'h0000_B5E5, H = 32'h8000_86BC, J = 32'h0000_8A7C;
  localparam longint MAXV = 64'h7FFF_FFFF;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [N*32-1:0] cur_in = '0;
  logic busy, done, ovf;
  logic [N-1:0] spike;
  logic [1:0] rd_addr = '0;
  logic [31:0] rd_v, rd_r;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {int a; logic [31:0] v; logic [31:0] r;} exp_t;
  exp_t sb[$];
  logic [31:0] mv [N];
  logic [31:0] mr [N];
  logic [N-1:0] m_spk;
  bit m_ovf, m_sat;
  wilson_array dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .cur_in(cur_in),
    .busy(busy), .done(done), .spike(spike), .ovf(ovf),
    .rd_addr(rd_addr), .rd_v(rd_v), .rd_r(rd_r)
  );
  always #5 clock = ~clock;
  function automatic longint sv(input logic [31:0] a);
    return a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
  endfunction
  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = (longint'(a[30:0]) * longint'(b[30:0])) >> 16;
    if (p > 64'h7FFF_FFFF) begin
      m_sat = 1'b1;
      p = 64'h7FFF_FFFF;
    end
    return {a[31] ^ b[31], p[30:0]};
  endfunction
  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = sv(a) + sv(b);
    if (s > MAXV) begin
      m_sat = 1'b1;
      s = MAXV;
    end else if (s < -MAXV) begin
      m_sat = 1'b1;
      s = -MAXV;
    end
    return s < 0 ? {1'b1, 31'(-s)} : {1'b0, 31'(s)};
  endfunction
  task automatic m_deriv(input logic [31:0] v, input logic [31:0] r, input logic [31:0] i,
                         output logic [31:0] dv, output logic [31:0] dr);
    logic [31:0] v2, v3;
    v2 = m_mul(v, v);
    v3 = m_mul(v, v2);
    dv = m_add(m_add(m_add(m_add(m_add(m_add(m_mul(CI, i), m_mul(A, v3)), m_mul(B, v2)),
         m_mul(m_mul(C, r), v)), m_mul(D, v)), m_mul(E, r)), F);
    dr = m_add(m_add(m_mul(G, v), m_mul(H, r)), J);
  endtask
  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = V_INIT;
      mr[k] = R_INIT;
    end
    m_spk = '0;
    m_ovf = 1'b0;
  endtask
  task automatic push_all();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.a = k;
      e.v = mv[k];
      e.r = mr[k];
      sb.push_back(e);
    end
  endtask
  task automatic m_step(input bit md, input logic [N*32-1:0] cur);
    logic [31:0] i, dv, dr, vm, rm, vn, rn;
    m_sat = 1'b0;
    for (int k = 0; k < N; k++) begin
      i = cur[k*32 +: 32];
      m_deriv(mv[k], mr[k], i, dv, dr);
      if (!md) begin
        vm = m_add(mv[k], m_mul(dv, DT >> 1));
        rm = m_add(mr[k], m_mul(dr, DT >> 1));
        m_deriv(vm, rm, i, dv, dr);
      end
      vn = m_add(mv[k], m_mul(dv, DT));
      rn = m_add(mr[k], m_mul(dr, DT));
      m_spk[k] = sv(mv[k]) < sv(VTH) && sv(vn) >= sv(VTH);
      mv[k] = vn;
      mr[k] = rn;
    end
    m_ovf = m_ovf | m_sat;
    push_all();
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = 2'(e.a);
      @(posedge clock);
      #1;
      chk($sformatf("rd_v[%0d]", e.a), rd_v, e.v);
      chk($sformatf("rd_r[%0d]", e.a), rd_r, e.r);
    end
  endtask
  task automatic step(input bit md, input logic [N*32-1:0] cur, input int pa, input int pb);
    int lat;
    m_step(md, cur);
    mode = md;
    cur_in = cur;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    mode = ~md;
    cur_in = ~cur;
    chk("busy_on_accept", 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      start = (lat == pa);
      @(posedge clock);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, md ? 2*N+1 : 3*N+1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("spike", 32'(spike), 32'(m_spk));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    start = (lat == pb);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    drain();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();
  endtask
  initial begin
    logic [N*32-1:0] cur4;
    int dones;
    cur4 = {32'h0014_0000, 32'h0005_0000, 32'h0001_0000, 32'h0};
    do_reset();
    chk("busy_rst", 32'(busy), 32'd0);
    chk("done_rst", 32'(done), 32'd0);
    chk("spike_rst", 32'(spike), 32'd0);
    chk("ovf_rst", 32'(ovf), 32'd0);
    push_all();
    drain();
    step(1'b1, '0, -1, -1);
    do_reset();
    for (int s = 0; s < 2000; s++)
      step(1'b0, cur4, s == 7 ? 3 : -1, s == 7 ? 13 : -1);
    step(1'b0, {96'h0, 32'h7FFF_0000}, -1, -1);
    step(1'b0, '0, -1, -1);
    step(1'b1, '0, -1, -1);
    mode = 1'b0;
    cur_in = cur4;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();
    chk("busy_abort", 32'(busy), 32'd0);
    chk("done_abort", 32'(done), 32'd0);
    chk("ovf_abort", 32'(ovf), 32'd0);
    chk("spike_abort", 32'(spike), 32'd0);
    dones = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) dones++;
    end
    chk("no_done_after_abort", dones, 0);
    push_all();
    drain();
    step(1'b0, cur4, -1, -1);
    step(1'b1, cur4, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
